// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: function codes, flag bit
// positions and the handshake FSM state type.
package alu_pkg;

  localparam logic [3:0] F_PASSB = 4'd0;
  localparam logic [3:0] F_ADD   = 4'd1;
  localparam logic [3:0] F_SUB   = 4'd2;
  localparam logic [3:0] F_AND   = 4'd3;
  localparam logic [3:0] F_OR    = 4'd4;
  localparam logic [3:0] F_XOR   = 4'd5;
  localparam logic [3:0] F_SHL   = 4'd6;
  localparam logic [3:0] F_SHR   = 4'd7;
  localparam logic [3:0] F_SRA   = 4'd8;
  localparam logic [3:0] F_MUL   = 4'd9;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] f);
    return (f == F_SHL) || (f == F_SHR) || (f == F_SRA);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath for shifts (one bit per cycle) and shift-add multiply
// (one partial product per cycle). done/result/carry describe the step being
// taken in the current cycle, so the caller can capture the final value on the
// same edge that completes the operation.
module alu_mc_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy;
  logic [3:0]         op_q;
  logic [CW-1:0]      cnt;
  // Shifts use the low half as the shift register; multiply uses the whole
  // register as {partial sum, remaining multiplier bits}.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step_prod;
  logic               step_cry;

  // One iteration of the selected operation.
  always_comb begin
    sum       = '0;
    step_prod = prod;
    step_cry  = 1'b0;
    case (op_q)
      F_SHL: begin
        step_prod[WIDTH-1:0] = {prod[WIDTH-2:0], 1'b0};
        step_cry             = prod[WIDTH-1];
      end
      F_SHR: begin
        step_prod[WIDTH-1:0] = {1'b0, prod[WIDTH-1:1]};
        step_cry             = prod[0];
      end
      F_SRA: begin
        step_prod[WIDTH-1:0] = {prod[WIDTH-1], prod[WIDTH-1:1]};
        step_cry             = prod[0];
      end
      default: begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                    ({1'b0, mcand} & {(WIDTH+1){prod[0]}});
        step_prod = {sum, prod[WIDTH-1:1]};
        step_cry  = |step_prod[2*WIDTH-1:WIDTH];
      end
    endcase
  end

  assign done   = busy && (cnt == CW'(1));
  assign result = step_prod[WIDTH-1:0];
  assign carry  = step_cry;

  // Load operands on start, then iterate until the step count runs out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      op_q  <= F_PASSB;
      cnt   <= '0;
      prod  <= '0;
      mcand <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      op_q  <= op;
      mcand <= a;
      if (op == F_MUL) begin
        prod <= {{WIDTH{1'b0}}, b};
        cnt  <= CW'(WIDTH);
      end else begin
        prod <= {{WIDTH{1'b0}}, a};
        cnt  <= CW'(b[SHW-1:0]);
      end
    end else if (busy) begin
      prod <= step_prod;
      cnt  <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle ops
// and zero-amount shifts complete in one cycle; non-zero shifts and multiply
// are handed to the iterative datapath. The result and flags are registered
// and held until the consumer takes them.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       alu_flags
);

  state_e state;

  logic                    accept;
  logic                    iter_start;
  logic                    iter_done;
  logic                    iter_carry;
  logic [WIDTH-1:0]        iter_result;
  logic [SHW-1:0]          shamt;

  logic [WIDTH:0]          add_full;
  logic [WIDTH-1:0]        sub_res;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]        sc_res;
  logic                    sc_c;
  logic                    sc_v;

  function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = (r == '0);
    f[FLG_N] = r[WIDTH-1];
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

  assign in_ready   = (state == IDLE) & ~rst;
  assign accept     = in_valid & in_ready;
  assign shamt      = alu_b[SHW-1:0];
  assign iter_start = accept &&
                      ((alu_func == F_MUL) || (is_shift(alu_func) && (shamt != '0)));

  assign a_s      = alu_a;
  assign b_s      = alu_b;
  assign add_full = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_res  = alu_a - alu_b;

  // Single-cycle result, carry and overflow; zero-amount shifts pass A through.
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (alu_func)
      F_PASSB: sc_res = alu_b;
      F_ADD: begin
        sc_res = add_full[WIDTH-1:0];
        sc_c   = add_full[WIDTH];
        sc_v   = (a_s[WIDTH-1] == b_s[WIDTH-1]) && (sc_res[WIDTH-1] != a_s[WIDTH-1]);
      end
      F_SUB: begin
        sc_res = sub_res;
        sc_c   = alu_a < alu_b;
        sc_v   = (a_s[WIDTH-1] != b_s[WIDTH-1]) && (sc_res[WIDTH-1] != a_s[WIDTH-1]);
      end
      F_AND:               sc_res = alu_a & alu_b;
      F_OR:                sc_res = alu_a | alu_b;
      F_XOR:               sc_res = alu_a ^ alu_b;
      F_SHL, F_SHR, F_SRA: sc_res = alu_a;
      default:             sc_res = '0;
    endcase
  end

  alu_mc_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .op     (alu_func),
    .a      (alu_a),
    .b      (alu_b),
    .done   (iter_done),
    .result (iter_result),
    .carry  (iter_carry)
  );

  // Handshake FSM; result and flags are captured on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      alu_flags <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (iter_start) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              alu_out   <= sc_res;
              alu_flags <= make_flags(sc_res, sc_c, sc_v);
            end
          end
        end
        BUSY: begin
          if (iter_done) begin
            state     <= DONE;
            out_valid <= 1'b1;
            alu_out   <= iter_result;
            alu_flags <= make_flags(iter_result, iter_carry, 1'b0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
